ps2_key_rx: RTL
===============

PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 Parameter FILTER, default 8: clk_sys cycles a synchronized PS/2 clock level must hold before it is accepted.
REQ-002 Parameter TIMEOUT, default 24000: clk_sys cycles without an accepted falling edge mid-frame before the frame is aborted.
REQ-003 clk_sys  in  1  system clock; all state in this domain.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 ps2_kbd_clk  in  1  raw keyboard clock line, asynchronous.
REQ-006 ps2_kbd_data  in  1  raw keyboard data line, asynchronous.
REQ-007 ps2_key  out  65  key event word: [64] toggle; [7:0] final byte; [15:8], [23:16] ... [63:56] preceding bytes of the same sequence, most recent first, zero where absent.
REQ-008 frame_err  out  1  one-cycle pulse on a rejected frame.

Function
REQ-009 Both raw lines pass through a 2-flop synchronizer before any use.
REQ-010 Filtered clock changes only after the synchronized clock holds a new level for FILTER consecutive cycles.
REQ-011 A bit is sampled from synchronized data on the cycle the filtered clock falls.
REQ-012 Frame: 11 bits, start = 0, 8 data bits LSB first, odd parity over data+parity, stop = 1.
REQ-013 Bit counter states: IDLE (0) -> DATA (1..8) -> PARITY (9) -> STOP (10) -> IDLE.
REQ-014 In IDLE, a sampled 1 is ignored; the counter stays 0.
REQ-015 A timeout counter clears on each accepted falling edge, counts only outside IDLE, and on reaching TIMEOUT returns to IDLE, discards partial data, and raises no frame_err.
REQ-016 Parity mismatch or stop bit = 0 pulses frame_err for one cycle, discards the byte, and clears the sequence buffer.
REQ-017 A good byte is delivered to the sequence assembler exactly one cycle after the stop-bit sample.
REQ-018 Sequence buffer: 64-bit shift register; each good byte shifts in at [7:0], older bytes move up 8 bits.
REQ-019 Byte E0 or F0 with pause count 0: shift in only; no event.
REQ-020 Byte E1: shift in and load pause count = 7; the next 7 bytes shift in with count decrementing; no event until count reaches 0.
REQ-021 Any other byte, or the byte that brings pause count to 0, completes the event: on the next cycle ps2_key[63:0] = buffer including that byte, ps2_key[64] inverts, buffer clears.
REQ-022 Buffer overflow (more than 8 bytes without completion) discards the oldest byte; the 8 most recent are kept.
REQ-023 ps2_key holds its value between events; exactly one toggle per completed event.
REQ-024 Latency: filtered falling edge of the stop bit to ps2_key update = 2 clk_sys cycles.

Reset
REQ-025 reset_n low asynchronously forces: ps2_key = 0 (toggle 0), frame_err = 0, bit counter IDLE, buffer 0, pause count 0, timeout counter 0, filtered clock = 1, synchronizers = 1.
REQ-026 Reset mid-frame or mid-sequence discards all partial data; after release the first valid frame is decoded normally.
REQ-027 Outputs change only on clk_sys edges after reset_n deasserts.

Verification
REQ-028 Frame 0x29, parity 0 -> ps2_key[63:0] = 0x29, [64] 0->1, 2 cycles after stop.
REQ-029 Frames F0, 29 -> one toggle; ps2_key[15:0] = 0xF029, [23:16] = 0.
REQ-030 Frames E0, F0, 75 -> one toggle; ps2_key[23:0] = 0xE0F075.
REQ-031 Pause: E1 14 77 E1 F0 14 F0 77 -> single toggle after the 8th byte; ps2_key[63:0] = 0xE11477E1F014F077.
REQ-032 Frame 0x1C with wrong parity -> frame_err pulse, no toggle; next good 0x1C -> ps2_key[7:0] = 0x1C, [15:8] = 0.
REQ-033 Clock stops after 5 bits for >TIMEOUT cycles, then good frame 0x6B -> no frame_err; ps2_key[7:0] = 0x6B; 3-cycle glitches on ps2_kbd_clk are ignored.

Source files
------------

// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard receiver assembling scan-code sequences into key event words
module ps2_key_rx #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 24000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_kbd_clk,
  input  logic        ps2_kbd_data,
  output logic [64:0] ps2_key,
  output logic        frame_err
);
  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FMAX = FW'(FILTER - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t        state;
  logic [1:0]    clk_sync, dat_sync;
  logic          clk_flt, clk_flt_d;
  logic [FW-1:0] flt_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift, byte_q;
  logic          par, byte_vld;
  logic [63:0]   seq_buf, nxt_buf;
  logic [2:0]    pause_cnt;
  logic          fall, bit_in, flt_hit, done;
  assign bit_in  = dat_sync[1];
  assign fall    = clk_flt_d & ~clk_flt;
  assign flt_hit = (clk_sync[1] != clk_flt) && (flt_cnt == FMAX);
  assign nxt_buf = {seq_buf[55:0], byte_q};
  assign done    = (pause_cnt != 3'd0) ? (pause_cnt == 3'd1)
                 : !(byte_q == 8'hE0 || byte_q == 8'hF0 || byte_q == 8'hE1);
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_kbd_clk};
      dat_sync <= {dat_sync[0], ps2_kbd_data};
    end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      clk_flt   <= 1'b1;
      clk_flt_d <= 1'b1;
      flt_cnt   <= '0;
    end else begin
      clk_flt_d <= clk_flt;
      flt_cnt   <= (clk_sync[1] == clk_flt || flt_hit) ? '0 : flt_cnt + 1'b1;
      if (flt_hit) clk_flt <= clk_sync[1];
    end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      bit_idx   <= '0;
      shift     <= '0;
      par       <= 1'b0;
      tmo_cnt   <= '0;
      byte_q    <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      tmo_cnt   <= (fall || state == IDLE) ? '0 : tmo_cnt + 1'b1;
      if (state != IDLE && !fall && tmo_cnt == TMAX) state <= IDLE;
      else if (fall)
        case (state)
          IDLE: if (!bit_in) begin
            state   <= DATA;
            bit_idx <= '0;
            par     <= 1'b0;
          end
          DATA: begin
            shift   <= {bit_in, shift[7:1]};
            par     <= par ^ bit_in;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= par ^ bit_in;
            state <= STOP;
          end
          default: begin
            state <= IDLE;
            if (bit_in && par) begin
              byte_q   <= shift;
              byte_vld <= 1'b1;
            end else frame_err <= 1'b1;
          end
        endcase
    end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      seq_buf   <= '0;
      pause_cnt <= '0;
      ps2_key   <= '0;
    end else if (frame_err) begin
      seq_buf   <= '0;
      pause_cnt <= '0;
    end else if (byte_vld) begin
      pause_cnt <= (pause_cnt != 3'd0) ? pause_cnt - 1'b1 : (byte_q == 8'hE1 ? 3'd7 : 3'd0);
      if (done) begin
        ps2_key <= {~ps2_key[64], nxt_buf};
        seq_buf <= '0;
      end else seq_buf <= nxt_buf;
    end
endmodule
